// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_ctrl
// Brief    : Async-FIFO write-side controller: full gating, RAM write port,
//            binary/Gray write pointers, sticky overflow flag and counter.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl #(
  parameter int ABITS = 10,
  parameter int DBITS = 16
) (
  input  logic             wrclk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wr_data,
  input  logic             wr_full,
  input  logic             ovf_clr,
  output logic [ABITS-1:0] wr_bin_ptr,
  output logic [ABITS-1:0] wr_gray_ptr,
  output logic             ram_we,
  output logic [ABITS-1:0] ram_waddr,
  output logic [DBITS-1:0] ram_wdata,
  output logic             wr_ack,
  output logic             wr_overflow,
  output logic [15:0]      ovf_cnt
);

  localparam logic [15:0] C_OVF_MAX = 16'hFFFF;

  logic             w_acc;
  logic             w_rej;
  logic [ABITS-1:0] w_nxt;

  logic [ABITS-1:0] bin_ptr_q,  bin_ptr_d;
  logic [ABITS-1:0] gray_ptr_q, gray_ptr_d;
  logic [ABITS-1:0] waddr_q,    waddr_d;
  logic [DBITS-1:0] wdata_q,    wdata_d;
  logic             we_q,       we_d;
  logic             ovf_q,      ovf_d;
  logic [15:0]      cnt_q,      cnt_d;

  assign w_acc = wr_en & ~wr_full;
  assign w_rej = wr_en &  wr_full;
  assign w_nxt = bin_ptr_q + ABITS'(1);

  always_comb begin
    bin_ptr_d  = bin_ptr_q;
    gray_ptr_d = gray_ptr_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;

    if (w_acc) begin
      we_d       = 1'b1;
      waddr_d    = bin_ptr_q;
      wdata_d    = wr_data;
      bin_ptr_d  = w_nxt;
      gray_ptr_d = w_nxt ^ (w_nxt >> 1);
    end

    // A reject coinciding with a clear counts as the first event after it
    if (ovf_clr) begin
      ovf_d = w_rej;
      cnt_d = w_rej ? 16'd1 : 16'd0;
    end else if (w_rej) begin
      ovf_d = 1'b1;
      if (cnt_q != C_OVF_MAX) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      bin_ptr_q  <= '0;
      gray_ptr_q <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bin_ptr_q  <= bin_ptr_d;
      gray_ptr_q <= gray_ptr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wr_bin_ptr  = bin_ptr_q;
  assign wr_gray_ptr = gray_ptr_q;
  assign ram_we      = we_q;
  assign wr_ack      = we_q;
  assign ram_waddr   = waddr_q;
  assign ram_wdata   = wdata_q;
  assign wr_overflow = ovf_q;
  assign ovf_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_ctrl
// Brief    : Self-checking bench for fifo_wr_ctrl (vector table, directed
//            corner sequences, randomized traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

  localparam int ABITS = 10;
  localparam int DBITS = 16;
  localparam int DEPTH = 1 << ABITS;

  logic             wrclk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [DBITS-1:0] wr_data;
  logic             wr_full;
  logic             ovf_clr;
  logic [ABITS-1:0] wr_bin_ptr;
  logic [ABITS-1:0] wr_gray_ptr;
  logic             ram_we;
  logic [ABITS-1:0] ram_waddr;
  logic [DBITS-1:0] ram_wdata;
  logic             wr_ack;
  logic             wr_overflow;
  logic [15:0]      ovf_cnt;

  fifo_wr_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .wrclk       (wrclk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_full     (wr_full),
    .ovf_clr     (ovf_clr),
    .wr_bin_ptr  (wr_bin_ptr),
    .wr_gray_ptr (wr_gray_ptr),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .wr_ack      (wr_ack),
    .wr_overflow (wr_overflow),
    .ovf_cnt     (ovf_cnt)
  );

  always #5 wrclk = ~wrclk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        en;
    logic        full;
    logic        clr;
    logic [15:0] d;
    logic        we;
    logic [9:0]  waddr;
    logic [15:0] wdata;
    logic [9:0]  ptr;
    logic        ovf;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  // Reference model: counts accepted writes; pointer is that count mod depth
  int          m_acc;
  logic        m_we;
  int          m_waddr;
  logic [15:0] m_wdata;
  logic        m_ovf;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] gray_of(input int n);
    logic [9:0] p;
    p = 10'(n % DEPTH);
    return p ^ (p >> 1);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_we = 0; m_waddr = 0; m_wdata = '0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic en, input logic full, input logic clr, input logic [15:0] d);
    bit rej;
    rej = en && full;
    if (en && !full) begin
      m_we    = 1;
      m_waddr = m_acc % DEPTH;
      m_wdata = d;
      m_acc++;
    end else begin
      m_we = 0;
    end
    if (clr) begin
      m_ovf = rej;
      m_cnt = rej ? 1 : 0;
    end else if (rej) begin
      m_ovf = 1;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ram_we"},      {31'd0, ram_we},      {31'd0, m_we});
    chk({tag, ".wr_ack"},      {31'd0, wr_ack},      {31'd0, m_we});
    chk({tag, ".ram_waddr"},   32'(ram_waddr),       32'(m_waddr));
    chk({tag, ".ram_wdata"},   32'(ram_wdata),       32'(m_wdata));
    chk({tag, ".wr_bin_ptr"},  32'(wr_bin_ptr),      32'(m_acc % DEPTH));
    chk({tag, ".wr_gray_ptr"}, 32'(wr_gray_ptr),     32'(gray_of(m_acc)));
    chk({tag, ".wr_overflow"}, {31'd0, wr_overflow}, {31'd0, m_ovf});
    chk({tag, ".ovf_cnt"},     32'(ovf_cnt),         32'(m_cnt));
  endtask

  // Drive inputs just after an edge, clock them in, update model, sample +1
  task automatic cycle(input logic en, input logic full, input logic clr, input logic [15:0] d);
    wr_en = en; wr_full = full; ovf_clr = clr; wr_data = d;
    @(posedge wrclk);
    model_step(en, full, clr, d);
    #1;
  endtask

  task automatic add(input logic en, input logic full, input logic clr, input logic [15:0] d,
                     input logic we, input logic [9:0] wa, input logic [15:0] wd,
                     input logic [9:0] ptr, input logic ovf, input logic [15:0] cnt);
    vec_t v;
    v.en = en; v.full = full; v.clr = clr; v.d = d; v.we = we; v.waddr = wa;
    v.wdata = wd; v.ptr = ptr; v.ovf = ovf; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  logic [9:0] prev_gray;
  logic [9:0] exp_g;

  initial begin
    // Vector table, starting from ptr=1 after the A5A5 write
    add(1,0,0,16'h1111, 1,10'd1,16'h1111,10'd2,0,16'd0);
    add(0,0,0,16'hDEAD, 0,10'd1,16'h1111,10'd2,0,16'd0);
    add(1,1,0,16'h2222, 0,10'd1,16'h1111,10'd2,1,16'd1);
    add(1,1,0,16'h2223, 0,10'd1,16'h1111,10'd2,1,16'd2);
    add(1,1,0,16'h2224, 0,10'd1,16'h1111,10'd2,1,16'd3);
    add(1,0,0,16'h3333, 1,10'd2,16'h3333,10'd3,1,16'd3);
    add(0,1,0,16'h4444, 0,10'd2,16'h3333,10'd3,1,16'd3);
    add(0,0,1,16'h0000, 0,10'd2,16'h3333,10'd3,0,16'd0);
    for (int i = 1; i <= 7; i++)
      add(1,1,0,16'h5555, 0,10'd2,16'h3333,10'd3,1,16'(i));
    add(1,1,1,16'h6666, 0,10'd2,16'h3333,10'd3,1,16'd1);
    add(0,0,1,16'h7777, 0,10'd2,16'h3333,10'd3,0,16'd0);

    // Reset held: outputs stay zero while wr_en toggles
    rst_n = 0; wr_en = 0; wr_full = 0; ovf_clr = 0; wr_data = 16'hFFFF;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = ~wr_en;
      @(posedge wrclk); #1;
      check_model("reset");
    end

    // Release mid-cycle; first edge with rst_n=1 accepts
    rst_n = 1;
    cycle(1, 0, 0, 16'hA5A5);
    chk("first.ram_we",      {31'd0, ram_we}, 32'd1);
    chk("first.ram_waddr",   32'(ram_waddr),   32'd0);
    chk("first.ram_wdata",   32'(ram_wdata),   32'hA5A5);
    chk("first.wr_bin_ptr",  32'(wr_bin_ptr),  32'd1);
    chk("first.wr_gray_ptr", 32'(wr_gray_ptr), 32'd1);

    foreach (tbl[i]) begin
      cycle(tbl[i].en, tbl[i].full, tbl[i].clr, tbl[i].d);
      exp_g = tbl[i].ptr ^ (tbl[i].ptr >> 1);
      chk($sformatf("tbl%0d.ram_we", i),      {31'd0, ram_we},      {31'd0, tbl[i].we});
      chk($sformatf("tbl%0d.wr_ack", i),      {31'd0, wr_ack},      {31'd0, tbl[i].we});
      chk($sformatf("tbl%0d.ram_waddr", i),   32'(ram_waddr),       32'(tbl[i].waddr));
      chk($sformatf("tbl%0d.ram_wdata", i),   32'(ram_wdata),       32'(tbl[i].wdata));
      chk($sformatf("tbl%0d.wr_bin_ptr", i),  32'(wr_bin_ptr),      32'(tbl[i].ptr));
      chk($sformatf("tbl%0d.wr_gray_ptr", i), 32'(wr_gray_ptr),     32'(exp_g));
      chk($sformatf("tbl%0d.wr_overflow", i), {31'd0, wr_overflow}, {31'd0, tbl[i].ovf});
      chk($sformatf("tbl%0d.ovf_cnt", i),     32'(ovf_cnt),         32'(tbl[i].cnt));
    end

    // Reset asserted between edges during a burst
    model_reset();
    rst_n = 0; @(posedge wrclk); #1; rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 16'(16'h0B00 + i));
      check_model("preburst");
    end
    #2 rst_n = 0;
    #1;
    chk("midrst.ram_we",      {31'd0, ram_we}, 32'd0);
    chk("midrst.wr_ack",      {31'd0, wr_ack}, 32'd0);
    chk("midrst.wr_bin_ptr",  32'(wr_bin_ptr),  32'd0);
    chk("midrst.wr_gray_ptr", 32'(wr_gray_ptr), 32'd0);
    chk("midrst.ram_waddr",   32'(ram_waddr),   32'd0);
    model_reset();
    @(posedge wrclk); #1;
    rst_n = 1;

    // 1030 back-to-back writes through the wrap
    prev_gray = 10'd0;
    for (int i = 0; i < 1030; i++) begin
      cycle(1, 0, 0, 16'($urandom));
      chk("burst.ram_waddr", 32'(ram_waddr), 32'(i % DEPTH));
      chk("burst.gray_hamming", 32'($countones(wr_gray_ptr ^ prev_gray)), 32'd1);
      check_model("burst");
      prev_gray = wr_gray_ptr;
    end
    chk("burst.final_bin",  32'(wr_bin_ptr),  32'd6);
    chk("burst.final_gray", 32'(wr_gray_ptr), 32'd5);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) == 0), 16'($urandom));
      check_model("rand");
    end

    // Saturation of the overflow counter
    cycle(0, 0, 1, 16'h0000);
    check_model("satclr");
    for (int i = 0; i < 65540; i++) begin
      cycle(1, 1, 0, 16'h1234);
      chk("sat.ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
      if (i == 65534 || i == 65539) begin
        chk("sat.value", 32'(ovf_cnt), 32'hFFFF);
        check_model("sat");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
